// File: rtl/bist_pkg.sv
// Shared types and helpers for the SRAM-port BIST engine: FSM encoding,
// test-pattern generation and a saturating counter step.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_CHECK   = 3'd5
    } bist_state_e;

    // Odd sweeps use the inverted address so every data bit toggles across sweeps.
    function automatic logic [15:0] bist_pattern(input logic [15:0] addr_lo, input logic flip);
        return flip ? ~addr_lo : addr_lo;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/bist_timeout_ctr.sv
// Per-transaction watchdog: loadable up-counter with clear and enable that
// flags expiry once it holds TIMEOUT_CYC-1.
module bist_timeout_ctr #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int CW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_enable,
    output logic          o_expired
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_count;

    // Counting stops at the limit so the expired flag holds until cleared.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/sram_bist_engine.sv
// Walks the wrapper's SRAM-like port with a fixed stride, writing a pattern,
// reading it back and comparing; tracks errors, first failure and hung transactions.
module sram_bist_engine
    import bist_pkg::*;
#(
    parameter int                ADDR_W      = 29,
    parameter int                STRIDE      = 50,
    parameter logic [ADDR_W-1:0] ADDR_MAX    = 29'h0FFFFFFF,
    parameter int                TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_calib_done,
    output logic [31:0]       o_addr,
    output logic              o_cs,
    output logic              o_l,
    output logic              o_u,
    output logic              o_we,
    output logic [15:0]       o_wr,
    input  logic [15:0]       i_rd,
    input  logic              i_ready,
    input  logic              i_busy,
    output logic              o_pass_pulse,
    output logic              o_fail_pulse,
    output logic [15:0]       o_err_count,
    output logic              o_first_err_valid,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic [15:0]       o_first_err_data,
    output logic              o_timeout,
    output logic [7:0]        o_sweeps,
    output logic [2:0]        o_state
);

    localparam int                CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] WRAP_AT  = ADDR_MAX - STRIDE_A;

    bist_state_e       r_state, w_state_next;
    logic [ADDR_W-1:0] r_cur_addr;
    logic              r_flip;
    logic              r_cs, r_we, r_lu;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wr;
    logic              r_pass, r_fail;
    logic [15:0]       r_err_count;
    logic              r_fe_valid;
    logic [ADDR_W-1:0] r_fe_addr;
    logic [15:0]       r_fe_data;
    logic              r_timeout;
    logic [7:0]        r_sweeps;

    logic              w_start_wr, w_start_rd, w_drop, w_rd_done, w_tmo, w_advance;
    logic              w_ctr_clear, w_ctr_en, w_expired;
    logic              w_wrap, w_adv_flip, w_req_flip;
    logic [ADDR_W-1:0] w_adv_addr, w_req_addr;
    logic [15:0]       w_pat;

    assign w_pat      = bist_pattern(r_cur_addr[15:0], r_flip);
    assign w_wrap     = (r_cur_addr > WRAP_AT);
    assign w_adv_addr = w_wrap ? '0 : r_cur_addr + STRIDE_A;
    assign w_adv_flip = r_flip ^ w_wrap;
    // A write launched from CHECK must already target the advanced address.
    assign w_req_addr = (r_state == ST_CHECK) ? w_adv_addr : r_cur_addr;
    assign w_req_flip = (r_state == ST_CHECK) ? w_adv_flip : r_flip;

    bist_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CW          (CW)
    ) u_timeout_ctr (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_clear    (w_ctr_clear),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_enable   (w_ctr_en),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ready has priority over both busy and the watchdog in the wait states.
    always_comb begin
        w_state_next = r_state;
        w_start_wr   = 1'b0;
        w_start_rd   = 1'b0;
        w_drop       = 1'b0;
        w_rd_done    = 1'b0;
        w_tmo        = 1'b0;
        w_advance    = 1'b0;
        w_ctr_clear  = 1'b0;
        w_ctr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && i_calib_done && !i_busy) begin
                    w_state_next = ST_WR_REQ;
                    w_start_wr   = 1'b1;
                end
            end
            ST_WR_REQ: begin
                w_ctr_clear  = 1'b1;
                w_state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                w_ctr_en = 1'b1;
                if (i_ready) begin
                    w_drop       = 1'b1;
                    w_start_rd   = 1'b1;
                    w_state_next = ST_RD_REQ;
                end else if (w_expired) begin
                    w_drop       = 1'b1;
                    w_tmo        = 1'b1;
                    w_state_next = ST_CHECK;
                end else if (i_busy) begin
                    w_drop = 1'b1;
                end
            end
            ST_RD_REQ: begin
                w_ctr_clear  = 1'b1;
                w_state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_ctr_en = 1'b1;
                if (i_ready) begin
                    w_drop       = 1'b1;
                    w_rd_done    = 1'b1;
                    w_state_next = ST_CHECK;
                end else if (w_expired) begin
                    w_drop       = 1'b1;
                    w_tmo        = 1'b1;
                    w_state_next = ST_CHECK;
                end else if (i_busy) begin
                    w_drop = 1'b1;
                end
            end
            ST_CHECK: begin
                w_advance = 1'b1;
                if (i_enable) begin
                    w_state_next = ST_WR_REQ;
                    w_start_wr   = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The verdict is registered on the ready edge so the strobe shows during CHECK.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cur_addr  <= '0;
            r_flip      <= 1'b0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_lu        <= 1'b0;
            r_addr      <= '0;
            r_wr        <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_err_count <= '0;
            r_fe_valid  <= 1'b0;
            r_fe_addr   <= '0;
            r_fe_data   <= '0;
            r_timeout   <= 1'b0;
            r_sweeps    <= '0;
        end else begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;

            if (w_start_wr) begin
                r_cs   <= 1'b1;
                r_we   <= 1'b1;
                r_lu   <= 1'b1;
                r_addr <= w_req_addr;
                r_wr   <= bist_pattern(w_req_addr[15:0], w_req_flip);
            end else if (w_start_rd) begin
                r_cs   <= 1'b1;
                r_we   <= 1'b0;
                r_lu   <= 1'b1;
                r_addr <= r_cur_addr;
                r_wr   <= '0;
            end else if (w_drop) begin
                r_cs   <= 1'b0;
                r_we   <= 1'b0;
                r_lu   <= 1'b0;
                r_addr <= '0;
                r_wr   <= '0;
            end

            if (w_advance) begin
                r_cur_addr <= w_adv_addr;
                r_flip     <= w_adv_flip;
                if (w_wrap) begin
                    r_sweeps <= r_sweeps + 8'd1;
                end
            end

            if (w_rd_done) begin
                if (i_rd == w_pat) begin
                    r_pass <= 1'b1;
                end else begin
                    r_fail      <= 1'b1;
                    r_err_count <= sat_inc16(r_err_count);
                    if (!r_fe_valid) begin
                        r_fe_valid <= 1'b1;
                        r_fe_addr  <= r_cur_addr;
                        r_fe_data  <= i_rd;
                    end
                end
            end

            if (w_tmo) begin
                r_fail      <= 1'b1;
                r_timeout   <= 1'b1;
                r_err_count <= sat_inc16(r_err_count);
                if (!r_fe_valid) begin
                    r_fe_valid <= 1'b1;
                    r_fe_addr  <= r_cur_addr;
                    r_fe_data  <= '0;
                end
            end
        end
    end

    assign o_addr            = {{(32-ADDR_W){1'b0}}, r_addr};
    assign o_cs              = r_cs;
    assign o_l               = r_lu;
    assign o_u               = r_lu;
    assign o_we              = r_we;
    assign o_wr              = r_wr;
    assign o_pass_pulse      = r_pass;
    assign o_fail_pulse      = r_fail;
    assign o_err_count       = r_err_count;
    assign o_first_err_valid = r_fe_valid;
    assign o_first_err_addr  = r_fe_addr;
    assign o_first_err_data  = r_fe_data;
    assign o_timeout         = r_timeout;
    assign o_sweeps          = r_sweeps;
    assign o_state           = r_state;

endmodule

// File: tb/tb_sram_bist_engine.sv
// Directed bench for sram_bist_engine against a small wrapper model
// (busy at +2, ready at +6) with per-address corruption and hang controls.
module tb_sram_bist_engine;

    localparam int          ADDR_W      = 29;
    localparam int          STRIDE      = 50;
    localparam logic [28:0] ADDR_MAX    = 29'd150;
    localparam int          TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_calib_done = 1'b0;
    logic [31:0] o_addr;
    logic        o_cs, o_l, o_u, o_we;
    logic [15:0] o_wr;
    logic [15:0] i_rd = 16'h0;
    logic        i_ready = 1'b0;
    logic        i_busy = 1'b0;
    logic        o_pass_pulse, o_fail_pulse;
    logic [15:0] o_err_count;
    logic        o_first_err_valid;
    logic [28:0] o_first_err_addr;
    logic [15:0] o_first_err_data;
    logic        o_timeout;
    logic [7:0]  o_sweeps;
    logic [2:0]  o_state;

    sram_bist_engine #(
        .ADDR_W      (ADDR_W),
        .STRIDE      (STRIDE),
        .ADDR_MAX    (ADDR_MAX),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk               (clk),
        .i_rst             (i_rst),
        .i_enable          (i_enable),
        .i_calib_done      (i_calib_done),
        .o_addr            (o_addr),
        .o_cs              (o_cs),
        .o_l               (o_l),
        .o_u               (o_u),
        .o_we              (o_we),
        .o_wr              (o_wr),
        .i_rd              (i_rd),
        .i_ready           (i_ready),
        .i_busy            (i_busy),
        .o_pass_pulse      (o_pass_pulse),
        .o_fail_pulse      (o_fail_pulse),
        .o_err_count       (o_err_count),
        .o_first_err_valid (o_first_err_valid),
        .o_first_err_addr  (o_first_err_addr),
        .o_first_err_data  (o_first_err_data),
        .o_timeout         (o_timeout),
        .o_sweeps          (o_sweeps),
        .o_state           (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isWr;
        logic [31:0] addr;
        logic [15:0] data;
        int unsigned cyc;
    } txn_t;

    txn_t        txnQ[$];
    logic [15:0] mem [logic [31:0]];
    bit          corruptAt [logic [31:0]];
    bit          hangOn = 1'b0;
    logic [31:0] hangAddr = 32'h0;
    int unsigned cycleCount = 0;
    int unsigned readyCycle = 0;
    int unsigned lastPulseCycle = 0;
    int          passCount = 0;
    int          failCount = 0;
    int          checks = 0;
    int          errors = 0;

    bit          mActive = 1'b0;
    int          mCnt = 0;
    bit          mIsWr = 1'b0;
    bit          mHang = 1'b0;
    logic [31:0] mAddr = 32'h0;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Wrapper model runs 2 ns after the edge so it sees settled DUT outputs.
    always @(posedge clk) begin
        #2;
        if (mActive) begin
            mCnt++;
            if (mCnt > 6) mActive = 1'b0;
        end
        if (!mActive && o_cs) begin
            txn_t t;
            mActive = 1'b1;
            mCnt    = 0;
            mIsWr   = o_we;
            mAddr   = o_addr;
            mHang   = hangOn && !o_we && (o_addr == hangAddr);
            if (o_we) mem[o_addr] = o_wr;
            t.isWr = o_we;
            t.addr = o_addr;
            t.data = o_wr;
            t.cyc  = cycleCount;
            txnQ.push_back(t);
        end
        i_busy  = mActive && (mCnt >= 2) && (mCnt <= 5);
        i_ready = mActive && (mCnt == 6) && !mHang;
        if (i_ready && !mIsWr) begin
            i_rd = mem.exists(mAddr) ? mem[mAddr] : 16'h0;
            if (corruptAt.exists(mAddr)) i_rd = i_rd ^ 16'h0001;
        end
        if (i_ready) readyCycle = cycleCount;
    end

    always @(posedge clk) begin
        #1;
        if (o_pass_pulse) begin
            passCount++;
            lastPulseCycle = cycleCount;
        end
        if (o_fail_pulse) begin
            failCount++;
            lastPulseCycle = cycleCount;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic calib);
        @(negedge clk);
        i_rst        = rst;
        i_enable     = en;
        i_calib_done = calib;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectTxn(input string tag, input bit isWr, input logic [31:0] addr,
                             input logic [15:0] data, output int unsigned cyc);
        txn_t t;
        int   budget = 200;
        while (txnQ.size() == 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (txnQ.size() == 0) begin
            checkOutput({tag, "_seen"}, 32'd0, 32'd1);
            cyc = 0;
        end else begin
            t   = txnQ.pop_front();
            cyc = t.cyc;
            checkOutput({tag, "_we"}, {31'd0, t.isWr}, {31'd0, isWr});
            checkOutput({tag, "_addr"}, t.addr, addr);
            checkOutput({tag, "_data"}, {16'd0, t.data}, {16'd0, data});
        end
    endtask

    task automatic waitPulse(input string tag, input bit wantFail);
        int base   = wantFail ? failCount : passCount;
        int budget = 200;
        bit seen   = 1'b0;
        while (!seen && budget > 0) begin
            @(negedge clk);
            budget--;
            seen = ((wantFail ? failCount : passCount) != base);
        end
        checkOutput(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int unsigned cyc;
        int          waited;

        waitCycles(3);
        checkOutput("rst_cs", {31'd0, o_cs}, 32'd0);
        checkOutput("rst_state", {29'd0, o_state}, 32'd0);
        checkOutput("rst_addr", o_addr, 32'd0);
        checkOutput("rst_errcnt", {16'd0, o_err_count}, 32'd0);
        checkOutput("rst_sweeps", {24'd0, o_sweeps}, 32'd0);
        checkOutput("rst_fevalid", {31'd0, o_first_err_valid}, 32'd0);

        // First sweep: 0, 50, 100 (100 is not above 150-50), 150, then wrap.
        corruptAt[32'd100] = 1'b1;
        corruptAt[32'd150] = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectTxn("wr0", 1'b1, 32'd0, 16'h0000, cyc);
        expectTxn("rd0", 1'b0, 32'd0, 16'h0000, cyc);
        waitPulse("pass0", 1'b0);
        checkOutput("pass_latency", lastPulseCycle - readyCycle, 32'd1);
        expectTxn("wr50", 1'b1, 32'd50, 16'h0032, cyc);
        expectTxn("rd50", 1'b0, 32'd50, 16'h0000, cyc);
        waitPulse("pass50", 1'b0);
        expectTxn("wr100", 1'b1, 32'd100, 16'h0064, cyc);
        expectTxn("rd100", 1'b0, 32'd100, 16'h0000, cyc);
        waitPulse("fail100", 1'b1);
        checkOutput("errcnt1", {16'd0, o_err_count}, 32'd1);
        checkOutput("fevalid1", {31'd0, o_first_err_valid}, 32'd1);
        checkOutput("feaddr1", {3'd0, o_first_err_addr}, 32'd100);
        checkOutput("fedata1", {16'd0, o_first_err_data}, 32'h0065);
        expectTxn("wr150", 1'b1, 32'd150, 16'h0096, cyc);
        expectTxn("rd150", 1'b0, 32'd150, 16'h0000, cyc);
        waitPulse("fail150", 1'b1);
        checkOutput("errcnt2", {16'd0, o_err_count}, 32'd2);
        checkOutput("feaddr2", {3'd0, o_first_err_addr}, 32'd100);
        checkOutput("fedata2", {16'd0, o_first_err_data}, 32'h0065);
        expectTxn("wr_wrap", 1'b1, 32'd0, 16'hFFFF, cyc);
        checkOutput("sweeps1", {24'd0, o_sweeps}, 32'd1);
        checkOutput("timeout0", {31'd0, o_timeout}, 32'd0);

        // Enable drops while the read is outstanding: it still completes and checks.
        expectTxn("rd_wrap", 1'b0, 32'd0, 16'h0000, cyc);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("state_rdwait", {29'd0, o_state}, 32'd4);
        waitPulse("pass_drop", 1'b0);
        waitCycles(2);
        checkOutput("idle_after_drop", {29'd0, o_state}, 32'd0);
        waitCycles(20);
        checkOutput("no_txn_idle", txnQ.size(), 32'd0);
        checkOutput("cs_idle", {31'd0, o_cs}, 32'd0);

        // Reset in WR_WAIT of the flipped write at 50.
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectTxn("wr50_flip", 1'b1, 32'd50, 16'hFFCD, cyc);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("state_wrwait", {29'd0, o_state}, 32'd2);
        checkOutput("cs_before_rst", {31'd0, o_cs}, 32'd1);
        waitCycles(1);
        checkOutput("rst_mid_cs", {31'd0, o_cs}, 32'd0);
        checkOutput("rst_mid_state", {29'd0, o_state}, 32'd0);
        checkOutput("rst_mid_errcnt", {16'd0, o_err_count}, 32'd0);
        checkOutput("rst_mid_sweeps", {24'd0, o_sweeps}, 32'd0);
        checkOutput("rst_mid_fevalid", {31'd0, o_first_err_valid}, 32'd0);
        checkOutput("rst_mid_feaddr", {3'd0, o_first_err_addr}, 32'd0);
        waitCycles(10);
        txnQ.delete();

        // Calibration held low: nothing is issued.
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(30);
        checkOutput("calib_low_txn", txnQ.size(), 32'd0);
        checkOutput("calib_low_state", {29'd0, o_state}, 32'd0);
        hangOn   = 1'b1;
        hangAddr = 32'd0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        waited = 0;
        while (!o_cs && waited < 2) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("cs_within2", {31'd0, o_cs}, 32'd1);

        // Read at 0 never gets ready: watchdog fires and the walk moves on.
        expectTxn("wr0_b", 1'b1, 32'd0, 16'h0000, cyc);
        expectTxn("rd_hang", 1'b0, 32'd0, 16'h0000, cyc);
        waitCycles(8);
        checkOutput("hang_cs_dropped", {31'd0, o_cs}, 32'd0);
        checkOutput("hang_state", {29'd0, o_state}, 32'd4);
        waitPulse("timeout_fail", 1'b1);
        checkOutput("timeout_window",
                    {31'd0, ((lastPulseCycle - cyc) >= 16) && ((lastPulseCycle - cyc) <= 18)}, 32'd1);
        checkOutput("timeout_flag", {31'd0, o_timeout}, 32'd1);
        checkOutput("timeout_errcnt", {16'd0, o_err_count}, 32'd1);
        checkOutput("timeout_fevalid", {31'd0, o_first_err_valid}, 32'd1);
        checkOutput("timeout_feaddr", {3'd0, o_first_err_addr}, 32'd0);
        checkOutput("timeout_fedata", {16'd0, o_first_err_data}, 32'd0);
        expectTxn("wr50_after", 1'b1, 32'd50, 16'h0032, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
